fir_tap_accumulator: RTL and testbench

//  Downstream stage of the RoBA multiplier in the FIR datapath.
//  - Takes one signed 64-bit tap product per accepted beat.
//  - Sums NUM_TAPS consecutive products.
//  - Rounds, shifts and saturates the sum to one OUT_W filter output sample.
//  - Drives tap_idx so upstream coefficient/delay-line logic selects the next tap.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_round_sat.sv | 36 +++
 rtl/fir_tap_accumulator.sv | 77 +++++++
 tb/tb_fir_tap_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR datapath defaults, clog2 helper and output limits
package fir_pkg;

    localparam int NUM_TAPS_DEF  = 8;
    localparam int PROD_W_DEF    = 64;
    localparam int ACC_W_DEF     = 67;
    localparam int OUT_W_DEF     = 32;
    localparam int OUT_SHIFT_DEF = 15;

    localparam logic signed [OUT_W_DEF-1:0] OUT_MAX_DEF = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    localparam logic signed [OUT_W_DEF-1:0] OUT_MIN_DEF = {1'b1, {(OUT_W_DEF-1){1'b0}}};

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up, arithmetic shift and saturate ACC_W -> OUT_W
module fir_round_sat #(
    parameter int ACC_W     = 67,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

    // One guard bit keeps the rounding addend from overflowing the sum.
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] shifted;
    logic                  fits;

    assign wide = {sum[ACC_W-1], sum};

    generate
        if (OUT_SHIFT == 0) begin : g_no_shift
            assign shifted = wide;
        end else begin : g_shift
            localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
            assign shifted = (wide + $signed(HALF)) >>> OUT_SHIFT;
        end
    endgenerate

    // The value fits when every bit above the output sign bit matches it.
    assign fits = (shifted[ACC_W:OUT_W-1] == '0) || (shifted[ACC_W:OUT_W-1] == '1);
    assign sat  = !fits;
    assign data = fits ? shifted[OUT_W-1:0] : (shifted[ACC_W] ? SAT_LO : SAT_HI);

endmodule

// File: rtl/fir_tap_accumulator.sv
// rtl/fir_tap_accumulator.sv - sums NUM_TAPS tap products into one scaled output sample
module fir_tap_accumulator
    import fir_pkg::*;
#(
    parameter int NUM_TAPS  = NUM_TAPS_DEF,
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          prod_valid,
    input  logic signed [PROD_W-1:0]      prod_data,
    output logic                          prod_ready,
    output logic [clog2(NUM_TAPS)-1:0]    tap_idx,
    output logic                          out_valid,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_sat,
    input  logic                          out_ready
);

    localparam int              IDX_W    = clog2(NUM_TAPS);
    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] rs_data;
    logic                    rs_sat;
    logic                    accept;
    logic                    final_accept;

    assign prod_ready   = !out_valid || out_ready;
    assign accept       = prod_valid && prod_ready && !clear;
    assign final_accept = accept && (tap_idx == LAST_TAP);
    assign sum          = acc + {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};

    fir_round_sat #(
        .ACC_W    (ACC_W),
        .OUT_W    (OUT_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_round_sat (
        .sum (sum),
        .data(rs_data),
        .sat (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            tap_idx <= '0;
        end else if (clear || final_accept) begin
            acc     <= '0;
            tap_idx <= '0;
        end else if (accept) begin
            acc     <= sum;
            tap_idx <= tap_idx + IDX_W'(1);
        end
    end

    // A new sample may load in the same cycle the old one is taken, so no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (final_accept) begin
            out_valid <= 1'b1;
            out_data  <= rs_data;
            out_sat   <= rs_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// tb/tb_fir_tap_accumulator.sv - scoreboard bench for fir_tap_accumulator at OUT_SHIFT 0 and 15
module tb_fir_tap_accumulator;

    localparam int NT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        prod_valid;
    logic [63:0] prod_data;
    logic        out_ready;

    logic        pr0, pr15, ov0, ov15, os0, os15;
    logic [2:0]  ti0, ti15;
    logic [31:0] od0, od15;

    always #5 clk = ~clk;

    fir_tap_accumulator #(.NUM_TAPS(8), .PROD_W(64), .ACC_W(67), .OUT_W(32), .OUT_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(pr0), .tap_idx(ti0), .out_valid(ov0), .out_data(od0), .out_sat(os0),
        .out_ready(out_ready)
    );

    fir_tap_accumulator #(.NUM_TAPS(8), .PROD_W(64), .ACC_W(67), .OUT_W(32), .OUT_SHIFT(15)) dut15 (
        .clk(clk), .rst(rst), .clear(clear), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(pr15), .tap_idx(ti15), .out_valid(ov15), .out_data(od15), .out_sat(os15),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic [31:0] d0;
        logic        s0;
        logic [31:0] d15;
        logic        s15;
    } exp_t;

    exp_t               expq[$];
    int                 vectors = 0;
    int                 miscompares = 0;
    int                 rdy_mode = 1;
    logic signed [127:0] m_sum = '0;
    int                 m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: exact sum, floor((s + half) / 2^sh), clip to 32-bit signed range.
    function automatic void model_out(input logic signed [127:0] s, input int sh,
                                      output logic [31:0] d, output logic sat);
        logic signed [127:0] r;
        logic signed [127:0] mx;
        logic signed [127:0] mn;
        mx = (128'sd1 <<< 31) - 128'sd1;
        mn = -(128'sd1 <<< 31);
        if (sh == 0) r = s;
        else         r = (s + (128'sd1 <<< (sh - 1))) >>> sh;
        if (r > mx) begin
            d = mx[31:0]; sat = 1'b1;
        end else if (r < mn) begin
            d = mn[31:0]; sat = 1'b1;
        end else begin
            d = r[31:0];  sat = 1'b0;
        end
    endfunction

    task automatic set_ready();
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        set_ready();
        prod_valid = 1'b0;
    endtask

    task automatic send(input logic [63:0] p, input bit clr);
        int                 waits;
        logic               took;
        logic signed [63:0] ps;
        exp_t               e;
        waits = 0;
        ps    = p;
        @(negedge clk);
        set_ready();
        prod_valid = 1'b1;
        prod_data  = p;
        clear      = clr;
        #1;
        while (!pr0 && !clr) begin
            if (waits > 1000) begin
                chk("prod_ready_timeout", 64'(pr0), 64'd1);
                break;
            end
            waits++;
            @(negedge clk);
            set_ready();
            #1;
        end
        took = pr0;
        @(posedge clk);
        if (clr) begin
            m_sum = '0;
            m_cnt = 0;
        end else if (took) begin
            m_sum = m_sum + ps;
            m_cnt++;
            if (m_cnt == NT) begin
                model_out(m_sum, 0,  e.d0,  e.s0);
                model_out(m_sum, 15, e.d15, e.s15);
                expq.push_back(e);
                m_sum = '0;
                m_cnt = 0;
            end
        end
        #1;
        chk("tap_idx0",  64'(ti0),  64'(m_cnt));
        chk("tap_idx15", 64'(ti15), 64'(m_cnt));
        prod_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic send_sample(input logic [63:0] p0, input logic [63:0] rest);
        send(p0, 1'b0);
        for (int i = 1; i < NT; i++) send(rest, 1'b0);
    endtask

    // Monitor: compare both instances whenever a sample is handed off.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && ov0 && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", 64'(ov0), 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk("out_data0",  64'(od0),  64'(e.d0));
                    chk("out_sat0",   64'(os0),  64'(e.s0));
                    chk("out_valid15", 64'(ov15), 64'd1);
                    chk("out_data15", 64'(od15), 64'(e.d15));
                    chk("out_sat15",  64'(os15), 64'(e.s15));
                end
            end
        end
    end

    initial begin
        int               guard;
        logic signed [63:0] rv;
        rst = 1'b1; clear = 1'b0; prod_valid = 1'b0; prod_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_out_data",  64'(od0), 64'd0);
        chk("rst_out_sat",   64'(os0), 64'd0);
        chk("rst_tap_idx",   64'(ti0), 64'd0);
        chk("rst_prod_ready", 64'(pr0), 64'd1);

        rdy_mode = 1;
        for (int i = 1; i <= NT; i++) send(64'(i), 1'b0);
        send_sample(-64'sd1 <<< 40, -64'sd1 <<< 40);
        send_sample(64'sd1 <<< 40, 64'sd1 <<< 40);
        send_sample(64'd16384, 64'd0);
        send_sample(64'd16383, 64'd0);
        send_sample(-64'sd16384, 64'd0);
        send_sample(-64'sd16385, 64'd0);
        send_sample(64'sd1 <<< 60, 64'sd1 <<< 60);
        send_sample(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        send_sample(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);

        // Hold a finished sample while the producer keeps offering a product.
        repeat (4) idle();
        rdy_mode = 0;
        send_sample(64'd3, 64'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            out_ready  = 1'b0;
            prod_valid = 1'b1;
            prod_data  = 64'd7;
            #1;
            chk("stall_prod_ready", 64'(pr0), 64'd0);
            chk("stall_out_valid",  64'(ov0), 64'd1);
            chk("stall_tap_idx",    64'(ti0), 64'd0);
            chk("stall_out_data",   64'(od0), 64'(expq[0].d0));
        end
        rdy_mode = 1;
        send_sample(64'd7, 64'd7);

        send(64'd9, 1'b0);
        send(64'd9, 1'b0);
        send(64'd9, 1'b0);
        send(64'd9, 1'b1);
        send_sample(64'd5, 64'd5);

        for (int i = 0; i < 5; i++) send(64'd11, 1'b0);
        repeat (3) idle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(ov0), 64'd0);
        chk("arst_out_data",  64'(od0), 64'd0);
        chk("arst_out_sat",   64'(os0), 64'd0);
        chk("arst_tap_idx",   64'(ti0), 64'd0);
        expq.delete();
        m_sum = '0;
        m_cnt = 0;
        #1 rst = 1'b0;
        send_sample(64'd1, 64'd1);

        rdy_mode = 2;
        for (int n = 0; n < 320; n++) begin
            rv = {$urandom, $urandom};
            rv = rv >>> $urandom_range(0, 62);
            if ($urandom_range(0, 3) == 0) idle();
            send(rv, ($urandom_range(0, 39) == 0));
        end

        rdy_mode = 1;
        guard = 0;
        while (expq.size() != 0 && guard < 200) begin
            idle();
            guard++;
        end
        chk("drain_queue_empty", 64'(expq.size()), 64'd0);
        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
